alu_pipe: RTL and testbench



---
 rtl/alu_pkg.sv | 40 ++++
 rtl/alu_div_iter.sv | 74 +++++++
 rtl/alu_pipe.sv | 144 ++++++++++++++
 tb/tb_alu_pipe.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state type and decode helper for alu_pipe.
// Latency: none (declarations only).
// Backpressure: not applicable.
//
// Contents:
//   OP_ADD..OP_LTU : existing ISA opcodes (5 bits)
//   OP_DIVU/OP_REMU: iterative divide opcodes, meaningful only with ALU_DIV_EN
//   state_t        : control state {IDLE, DIV}
//   is_div_op()    : true for the two divide opcodes
package alu_pkg;

  localparam logic [4:0] OP_ADD  = 5'h00;
  localparam logic [4:0] OP_SUB  = 5'h01;
  localparam logic [4:0] OP_AND  = 5'h02;
  localparam logic [4:0] OP_OR   = 5'h03;
  localparam logic [4:0] OP_XOR  = 5'h04;
  localparam logic [4:0] OP_MUL  = 5'h05;
  localparam logic [4:0] OP_SHL  = 5'h06;
  localparam logic [4:0] OP_SHR  = 5'h07;
  localparam logic [4:0] OP_SHRA = 5'h08;
  localparam logic [4:0] OP_EQ   = 5'h09;
  localparam logic [4:0] OP_NEQ  = 5'h0A;
  localparam logic [4:0] OP_LT   = 5'h0B;
  localparam logic [4:0] OP_LE   = 5'h0C;
  localparam logic [4:0] OP_GT   = 5'h0D;
  localparam logic [4:0] OP_GE   = 5'h0E;
  localparam logic [4:0] OP_LTU  = 5'h0F;
  localparam logic [4:0] OP_DIVU = 5'h10;
  localparam logic [4:0] OP_REMU = 5'h11;

  typedef enum logic {
    IDLE = 1'b0,
    DIV  = 1'b1
  } state_t;

  function automatic logic is_div_op(input logic [4:0] op);
    return (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_div_iter.sv
// Unsigned restoring divider, one quotient bit per cycle, MSB first.
// Latency: start edge loads operands, WIDTH iteration edges follow, done rises after the last one.
// Backpressure: none; done and the results hold until the next start.
//
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   start               : load dividend/divisor and begin (ignored state is overwritten)
//   dividend, divisor   : WIDTH-bit unsigned operands, sampled on start
//   done                : quotient/remainder valid, cleared by the next start
//   quotient, remainder : results; divide by zero yields all-ones / dividend
module alu_div_iter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int SHW = $clog2(WIDTH);

  logic             busy;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             fits;

  // Partial remainder shifted left with the next dividend bit brought in.
  // A zero divisor always "fits", which naturally gives an all-ones quotient
  // and leaves the dividend as the remainder.
  assign shifted = {rem, quo[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs};
  assign fits    = !diff[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
      cnt  <= '0;
      rem  <= '0;
      quo  <= '0;
      dvs  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      done <= 1'b0;
      cnt  <= SHW'(WIDTH - 1);
      rem  <= '0;
      quo  <= dividend;
      dvs  <= divisor;
    end else if (busy) begin
      // Remainder never exceeds the divisor, so WIDTH bits suffice.
      rem <= fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
      // quo doubles as the dividend shifter and the quotient accumulator.
      quo <= {quo[WIDTH-2:0], fits};
      if (cnt == '0) begin
        busy <= 1'b0;
        done <= 1'b1;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign quotient  = quo;
  assign remainder = rem;

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready on both sides and an optional iterative divider (macro ALU_DIV_EN).
// Latency: non-divide result registered on the accept edge; divide result registered WIDTH+1 edges after accept.
// Backpressure: output register holds while out_ready=0; in_ready drops until it can drain, and during a divide.
//
// Ports:
//   clk, rst_n              : clock, async active-low reset
//   in_valid/in_ready       : operation handshake; opcode, a, b sampled on accept
//   opcode, a, b            : operation (alu_pkg encodings) and WIDTH-bit operands
//   out_valid/out_ready     : result handshake
//   result, zero            : registered result and result==0 flag
// Without ALU_DIV_EN the divider is absent and DIVU/REMU decode as undefined (result 0).
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

  logic [WIDTH-1:0] alu_res;
  logic             big_sh;
  logic [SHW-1:0]   shamt;
  logic             out_free;
  logic             accept;
  logic             acc_alu;

  // Shift amount is the whole of b; anything past WIDTH saturates.
  assign big_sh = (b >= WIDTH_V);
  assign shamt  = b[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (opcode)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      // Low half of a product is identical for signed and unsigned operands.
      OP_MUL:  alu_res = a * b;
      OP_SHL:  alu_res = big_sh ? '0 : (a << shamt);
      OP_SHR:  alu_res = big_sh ? '0 : (a >> shamt);
      OP_SHRA: alu_res = big_sh ? {WIDTH{a[WIDTH-1]}} : ($signed(a) >>> shamt);
      OP_EQ:   alu_res = {{(WIDTH-1){1'b0}}, a == b};
      OP_NEQ:  alu_res = {{(WIDTH-1){1'b0}}, a != b};
      OP_LT:   alu_res = {{(WIDTH-1){1'b0}}, $signed(a) <  $signed(b)};
      OP_LE:   alu_res = {{(WIDTH-1){1'b0}}, $signed(a) <= $signed(b)};
      OP_GT:   alu_res = {{(WIDTH-1){1'b0}}, $signed(a) >  $signed(b)};
      OP_GE:   alu_res = {{(WIDTH-1){1'b0}}, $signed(a) >= $signed(b)};
      OP_LTU:  alu_res = {{(WIDTH-1){1'b0}}, a < b};
      default: alu_res = '0;
    endcase
  end

  // Output register can take a new value if empty or draining this edge.
  assign out_free = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

`ifdef ALU_DIV_EN
  state_t           state;
  logic             op_div;
  logic             acc_div;
  logic             div_fin;
  logic             div_done;
  logic             is_rem;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] div_r;
  logic [WIDTH-1:0] div_res;

  assign op_div   = is_div_op(opcode);
  assign in_ready = (state == IDLE) && out_free;
  assign acc_alu  = accept && !op_div;
  assign acc_div  = accept && op_div;
  // A finished divide waits in DIV until the output register is free.
  assign div_fin  = (state == DIV) && div_done && out_free;
  assign div_res  = is_rem ? div_r : div_q;

  alu_div_iter #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (acc_div),
    .dividend (a),
    .divisor  (b),
    .done     (div_done),
    .quotient (div_q),
    .remainder(div_r)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      is_rem <= 1'b0;
    end else begin
      case (state)
        IDLE: if (acc_div) begin
          state  <= DIV;
          is_rem <= (opcode == OP_REMU);
        end
        DIV:  if (div_fin) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign in_ready = out_free;
  assign acc_alu  = accept;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
    end else if (acc_alu) begin
      out_valid <= 1'b1;
      result    <= alu_res;
      zero      <= (alu_res == '0);
`ifdef ALU_DIV_EN
    end else if (div_fin) begin
      out_valid <= 1'b1;
      result    <= div_res;
      zero      <= (div_res == '0);
`endif
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=16): directed scenarios plus randomized traffic
// against an arithmetic reference model and an in-order scoreboard.
// Works with or without ALU_DIV_EN; divide expectations follow the macro.
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int W = 16;
`ifdef ALU_DIV_EN
  localparam bit DIV_ON  = 1'b1;
  localparam int DIV_LAT = W + 1;
`else
  localparam bit DIV_ON  = 1'b0;
  localparam int DIV_LAT = 0;
`endif

  logic         clk      = 1'b0;
  logic         rst_n    = 1'b0;
  logic         in_valid = 1'b0;
  logic         dir_rdy  = 1'b1;
  logic         rand_bp  = 1'b0;
  logic         rnd_bit  = 1'b1;
  logic [4:0]   opcode   = '0;
  logic [W-1:0] a        = '0;
  logic [W-1:0] b        = '0;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;

  int n_chk  = 0;
  int n_fail = 0;
  logic [W-1:0] sb[$];

  assign out_ready = rand_bp ? rnd_bit : dir_rdy;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .opcode   (opcode),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .zero     (zero)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model straight from the operation definitions, using integer arithmetic.
  function automatic logic [W-1:0] model(input logic [4:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    int    ux = int'(x);
    int    uy = int'(y);
    int    sx = int'($signed(x));
    int    sy = int'($signed(y));
    longint p;
    case (op)
      OP_ADD:  return W'(ux + uy);
      OP_SUB:  return W'(ux - uy);
      OP_AND:  return x & y;
      OP_OR:   return x | y;
      OP_XOR:  return x ^ y;
      OP_MUL:  begin p = longint'(sx) * longint'(sy); return W'(p); end
      OP_SHL:  return (uy >= W) ? '0 : W'(ux << uy);
      OP_SHR:  return (uy >= W) ? '0 : W'(ux >> uy);
      OP_SHRA: begin
        if (uy >= W) return (sx < 0) ? '1 : '0;
        return W'(sx >>> uy);
      end
      OP_EQ:   return W'(ux == uy);
      OP_NEQ:  return W'(ux != uy);
      OP_LT:   return W'(sx <  sy);
      OP_LE:   return W'(sx <= sy);
      OP_GT:   return W'(sx >  sy);
      OP_GE:   return W'(sx >= sy);
      OP_LTU:  return W'(ux <  uy);
      OP_DIVU: begin
        if (!DIV_ON) return '0;
        return (uy == 0) ? '1 : W'(ux / uy);
      end
      OP_REMU: begin
        if (!DIV_ON) return '0;
        return (uy == 0) ? x : W'(ux % uy);
      end
      default: return '0;
    endcase
  endfunction

  // Present an operation and queue its expected result (caller guarantees acceptance).
  task automatic drive(input logic [4:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    opcode   = op;
    a        = x;
    b        = y;
    in_valid = 1'b1;
    sb.push_back(model(op, x, y));
  endtask

  // Present an operation and hold it until accepted; returns at accept edge + 1.
  task automatic issue(input logic [4:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    bit acc = 1'b0;
    drive(op, x, y);
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) chk("accept_timeout", 32'(acc), 32'd1);
  endtask

  // Issue with out_ready=1, measure edges to out_valid and stalled in_ready samples, check result.
  task automatic op_check(input string tag, input logic [4:0] op, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic [W-1:0] exp_res, input int exp_lat);
    int n    = 0;
    int busy = 0;
    issue(op, x, y);
    while (!out_valid && n < 100) begin
      if (!in_ready) busy++;
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_lat"},  32'(n),       32'(exp_lat));
    chk({tag, "_busy"}, 32'(busy),    32'(exp_lat));
    chk({tag, "_res"},  32'(result),  32'(exp_res));
    chk({tag, "_zero"}, 32'(zero),    32'(exp_res == '0));
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom % 6)
      0: return '0;
      1: return W'(1);
      2: return 16'h7FFF;
      3: return 16'h8000;
      4: return 16'hFFFF;
      default: return W'($urandom);
    endcase
  endfunction

  // Random out_ready changes well away from both clock edges.
  always @(posedge clk) begin
    #2;
    rnd_bit = ($urandom_range(0, 2) != 0);
  end

  // Scoreboard: every completed output handshake must match the oldest expectation.
  always @(negedge clk) begin
    logic [W-1:0] exp;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_spurious", 32'(result), 32'hDEAD_BEEF);
      end else begin
        exp = sb.pop_front();
        chk("sb_result", 32'(result), 32'(exp));
        chk("sb_zero",   32'(zero),   32'(exp == '0));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    logic [4:0]   rop;
    logic [W-1:0] rx;
    logic [W-1:0] ry;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result",    32'(result),    32'd0);
    chk("rst_zero",      32'(zero),      32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Back-to-back with out_ready=1: one result per cycle
    drive(OP_ADD, 16'h7FFF, 16'h0001);
    @(posedge clk); #1;
    chk("b2b_add", 32'(result), 32'h8000);
    chk("b2b_add_zero", 32'(zero), 32'd0);
    chk("b2b_rdy1", 32'(in_ready), 32'd1);
    drive(OP_SUB, 16'h0000, 16'h0001);
    @(posedge clk); #1;
    chk("b2b_sub", 32'(result), 32'hFFFF);
    chk("b2b_sub_zero", 32'(zero), 32'd0);
    chk("b2b_rdy2", 32'(in_ready), 32'd1);
    drive(OP_MUL, 16'hFFFF, 16'h0003);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b_mul", 32'(result), 32'hFFFD);
    chk("b2b_mul_zero", 32'(zero), 32'd0);
    chk("b2b_valid", 32'(out_valid), 32'd1);

    // Shifts, compares, divides
    op_check("shra_big", OP_SHRA, 16'h8000, 16'd20, 16'hFFFF, 0);
    op_check("shl_16",   OP_SHL,  16'h0001, 16'd16, 16'h0000, 0);
    op_check("lt",       OP_LT,   16'hFFFF, 16'h0001, 16'h0001, 0);
    op_check("ltu",      OP_LTU,  16'hFFFF, 16'h0001, 16'h0000, 0);
    op_check("divu",     OP_DIVU, 16'd100, 16'd7, DIV_ON ? 16'd14 : 16'd0, DIV_LAT);
    op_check("remu",     OP_REMU, 16'd100, 16'd7, DIV_ON ? 16'd2  : 16'd0, DIV_LAT);
    op_check("divu_z",   OP_DIVU, 16'h1234, 16'd0, DIV_ON ? 16'hFFFF : 16'd0, DIV_LAT);
    op_check("remu_z",   OP_REMU, 16'h1234, 16'd0, DIV_ON ? 16'h1234 : 16'd0, DIV_LAT);

    // Backpressure: result held, then drain and accept on the same edge
    @(posedge clk); #1;
    dir_rdy = 1'b0;
    issue(OP_ADD, 16'd3, 16'd4);
    drive(OP_XOR, 16'd5, 16'd5);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_res",   32'(result),    32'd7);
      chk("bp_hold_rdy",   32'(in_ready),  32'd0);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
    end
    dir_rdy = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_xor_valid", 32'(out_valid), 32'd1);
    chk("bp_xor_res",   32'(result),    32'd0);
    chk("bp_xor_zero",  32'(zero),      32'd1);

    // Reset in the middle of a divide
    @(posedge clk); #1;
    issue(OP_DIVU, 16'd100, 16'd7);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rstdiv_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.delete();
    chk("rstdiv_in_ready", 32'(in_ready), 32'd1);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) cnt++;
    end
    chk("rstdiv_no_result", 32'(cnt), 32'd0);
    op_check("post_rst_add", OP_ADD, 16'd1, 16'd1, 16'd2, 0);

    // Randomized traffic with random output backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom % 5 == 0) rop = ($urandom % 2 == 0) ? OP_DIVU : OP_REMU;
      else                   rop = 5'($urandom_range(0, 31));
      rx = pick();
      ry = ($urandom % 3 == 0) ? W'($urandom_range(0, 20)) : pick();
      issue(rop, rx, ry);
      if ($urandom % 4 == 0) begin
        @(posedge clk); #1;
      end
    end
    rand_bp = 1'b0;
    cnt = 0;
    while (sb.size() != 0 && cnt < 200) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("sb_drain", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
